// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the burst read/write memory controller.
// Holds the controller state encoding and default geometry constants.
package mem_ctrl_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ADDR_W_DEF = 6;
    localparam int unsigned LEN_W_DEF  = 4;
    localparam int unsigned WIN_W_DEF  = 3;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GRANT    = 3'd1,
        WR       = 3'd2,
        RD_FETCH = 3'd3,
        RD_DATA  = 3'd4
    } state_e;

endpackage

// File: rtl/mem_sp_ram.sv
// Single-port RAM: synchronous write, registered read.
// Only the read register is reset; array contents survive reset.
module mem_sp_ram #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_addr] <= i_wdata;
        end
    end

    // Read data holds between fetches so the consumer sees a stable beat.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rdata_q <= '0;
        end else if (i_re) begin
            rdata_q <= mem_q[i_addr];
        end
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/mem_burst_rw_ctrl.sv
// Burst read/write controller in front of a single-port RAM.
// Supports linear and window-wrapping bursts with round-robin request arbitration.
module mem_burst_rw_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned LEN_W  = LEN_W_DEF,
    parameter int unsigned WIN_W  = WIN_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_wr_req,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_wr_valid,
    output logic              o_wr_done,
    input  logic              i_rd_req,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_valid,
    input  logic              i_rd_done,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [LEN_W-1:0]  i_num_b,
    input  logic              i_wrap,
    output logic              o_ack,
    output logic              o_err,
    output logic              o_busy
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              wrap_q, wrap_d;
    logic              is_wr_q, is_wr_d;
    logic              prio_q, prio_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              wr_done_q, wr_done_d;
    logic              rd_valid_q, rd_valid_d;
    logic              ram_we, ram_re;
    logic              grant_wr;

    // Wrapping keeps the upper address bits and rolls the low WIN_W bits.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                    input logic wrap);
        logic [ADDR_W-1:0] lin;
        logic [ADDR_W-1:0] mask;
        lin  = a + ADDR_W'(1);
        mask = ADDR_W'((1 << WIN_W) - 1);
        return wrap ? ((a & ~mask) | (lin & mask)) : lin;
    endfunction

    // prio_q == 0 favours write on contention.
    assign grant_wr = i_wr_req && (!i_rd_req || !prio_q);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        wrap_d     = wrap_q;
        is_wr_d    = is_wr_q;
        prio_d     = prio_q;
        err_d      = 1'b0;
        wr_done_d  = 1'b0;
        ram_we     = 1'b0;
        ram_re     = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_wr_req || i_rd_req) begin
                    if (i_num_b == '0) begin
                        err_d = 1'b1;
                    end else begin
                        is_wr_d = grant_wr;
                        addr_d  = i_addr;
                        rem_d   = i_num_b;
                        wrap_d  = i_wrap;
                        prio_d  = ~prio_q;
                        state_d = GRANT;
                    end
                end
            end
            GRANT: begin
                state_d = is_wr_q ? WR : RD_FETCH;
            end
            WR: begin
                if (i_wr_valid) begin
                    ram_we    = 1'b1;
                    wr_done_d = 1'b1;
                    addr_d    = next_addr(addr_q, wrap_q);
                    rem_d     = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            RD_FETCH: begin
                ram_re  = 1'b1;
                state_d = RD_DATA;
            end
            RD_DATA: begin
                if (i_rd_done) begin
                    addr_d  = next_addr(addr_q, wrap_q);
                    rem_d   = rem_q - LEN_W'(1);
                    state_d = (rem_q == LEN_W'(1)) ? IDLE : RD_FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A write beat coinciding with reset must not land in memory.
        if (i_reset) begin
            ram_we = 1'b0;
        end

        ack_d      = (state_d == GRANT);
        busy_d     = (state_d != IDLE);
        rd_valid_d = (state_d == RD_DATA);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            wrap_q     <= 1'b0;
            is_wr_q    <= 1'b0;
            prio_q     <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            wr_done_q  <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            wrap_q     <= wrap_d;
            is_wr_q    <= is_wr_d;
            prio_q     <= prio_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            wr_done_q  <= wr_done_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    mem_sp_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_we    (ram_we),
        .i_re    (ram_re),
        .i_addr  (addr_q),
        .i_wdata (i_wr_data),
        .o_rdata (o_rd_data)
    );

    assign o_ack      = ack_q;
    assign o_err      = err_q;
    assign o_busy     = busy_q;
    assign o_wr_done  = wr_done_q;
    assign o_rd_valid = rd_valid_q;

endmodule

// File: tb/tb_mem_burst_rw_ctrl.sv
// Self-checking bench for mem_burst_rw_ctrl: table of bursts plus directed
// sequences for reset abort and arbitration; read data checked via a queue.
module tb_mem_burst_rw_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_req, wr_valid, wr_done;
    logic [7:0] wr_data;
    logic       rd_req, rd_valid, rd_done;
    logic [7:0] rd_data;
    logic [5:0] addr;
    logic [3:0] num_b;
    logic       wrap;
    logic       ack, err, busy;

    int total = 0;
    int bad   = 0;

    logic [7:0] ref_mem [64];
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    mem_burst_rw_ctrl dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_wr_req   (wr_req),
        .i_wr_data  (wr_data),
        .i_wr_valid (wr_valid),
        .o_wr_done  (wr_done),
        .i_rd_req   (rd_req),
        .o_rd_data  (rd_data),
        .o_rd_valid (rd_valid),
        .i_rd_done  (rd_done),
        .i_addr     (addr),
        .i_num_b    (num_b),
        .i_wrap     (wrap),
        .o_ack      (ack),
        .o_err      (err),
        .o_busy     (busy)
    );

    typedef struct {
        logic       is_wr;
        logic [5:0] addr;
        logic [3:0] num;
        logic       wrap;
        logic [7:0] d0;
        logic       exp_err;
        logic [7:0] exp_first;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] nxt(input logic [5:0] a, input logic w);
        logic [2:0] lo;
        lo = a[2:0] + 3'd1;
        return w ? {a[5:3], lo} : 6'(a + 6'd1);
    endfunction

    task automatic idle_inputs();
        wr_req = 1'b0; rd_req = 1'b0; wr_valid = 1'b0; wr_data = 8'h00;
        rd_done = 1'b0; addr = 6'd0; num_b = 4'd0; wrap = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack"}, 32'(ack), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_wr_done"}, 32'(wr_done), 0);
        chk({tag, "_rd_valid"}, 32'(rd_valid), 0);
        chk({tag, "_rd_data"}, 32'(rd_data), 0);
    endtask

    // Issue a request, then scramble the request fields to prove they were latched.
    task automatic do_req(input logic is_wr, input logic [5:0] a, input logic [3:0] n,
                          input logic w, output bit granted);
        @(negedge clk);
        wr_req = is_wr; rd_req = !is_wr; addr = a; num_b = n; wrap = w;
        @(negedge clk);
        wr_req = 1'b0; rd_req = 1'b0; addr = ~a; num_b = 4'(n + 4'd3); wrap = !w;
        if (n == 4'd0) begin
            chk("err_pulse", 32'(err), 1);
            chk("err_no_ack", 32'(ack), 0);
            chk("err_idle", 32'(busy), 0);
            @(negedge clk);
            chk("err_one_cycle", 32'(err), 0);
            chk("err_stays_idle", 32'(busy), 0);
            granted = 1'b0;
        end else begin
            chk("ack", 32'(ack), 1);
            chk("busy_grant", 32'(busy), 1);
            chk("no_err", 32'(err), 0);
            @(negedge clk);
            chk("ack_one_cycle", 32'(ack), 0);
            granted = 1'b1;
        end
    endtask

    task automatic do_write(input logic [5:0] a, input logic [3:0] n, input logic w,
                            input logic [7:0] d0, input int stall_beat, output bit granted);
        logic [5:0] cur;
        do_req(1'b1, a, n, w, granted);
        if (!granted) return;
        cur = a;
        for (int i = 0; i < int'(n); i++) begin
            if (i == stall_beat) begin
                wr_valid = 1'b0; wr_data = 8'hFF;
                @(negedge clk);
                chk("stall_no_done", 32'(wr_done), 0);
                chk("stall_busy", 32'(busy), 1);
            end
            wr_valid = 1'b1;
            wr_data  = 8'(d0 + 8'(i));
            ref_mem[cur] = wr_data;
            cur = nxt(cur, w);
            @(negedge clk);
            chk("wr_done", 32'(wr_done), 1);
        end
        wr_valid = 1'b0;
        chk("wr_end_idle", 32'(busy), 0);
        @(negedge clk);
        chk("wr_done_drop", 32'(wr_done), 0);
    endtask

    task automatic do_read(input logic [5:0] a, input logic [3:0] n, input logic w,
                           input int hold, output bit granted, output logic [7:0] first);
        logic [5:0] cur;
        logic [7:0] held;
        logic [7:0] e;
        int t;
        first = 8'h00;
        cur = a;
        for (int i = 0; i < int'(n); i++) begin
            exp_q.push_back(ref_mem[cur]);
            cur = nxt(cur, w);
        end
        do_req(1'b0, a, n, w, granted);
        if (!granted) return;
        for (int i = 0; i < int'(n); i++) begin
            t = 0;
            while (!rd_valid && t < 8) begin
                @(negedge clk);
                t++;
            end
            chk("rd_fetch_latency", 32'(t), 1);
            held = rd_data;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                chk("rd_hold_valid", 32'(rd_valid), 1);
                chk("rd_hold_data", 32'(rd_data), 32'(held));
            end
            if (i == 0) first = rd_data;
            rd_done = 1'b1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rd_data", 32'(rd_data), 32'(e));
            end else begin
                chk("rd_queue_empty", 32'(exp_q.size()), 1);
            end
            @(negedge clk);
            rd_done = 1'b0;
        end
        chk("rd_end_idle", 32'(busy), 0);
        chk("rd_end_valid", 32'(rd_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit         g;
        logic [7:0] f;

        vecs[0]  = '{1'b1, 6'd8,  4'd1, 1'b0, 8'h88, 1'b0, 8'h00};
        vecs[1]  = '{1'b1, 6'd16, 4'd4, 1'b0, 8'h10, 1'b0, 8'h00};
        vecs[2]  = '{1'b1, 6'd6,  4'd4, 1'b1, 8'h0A, 1'b0, 8'h00};
        vecs[3]  = '{1'b0, 6'd6,  4'd4, 1'b1, 8'h00, 1'b0, 8'h0A};
        vecs[4]  = '{1'b0, 6'd8,  4'd1, 1'b0, 8'h00, 1'b0, 8'h88};
        vecs[5]  = '{1'b0, 6'd0,  4'd3, 1'b0, 8'h00, 1'b0, 8'h0C};
        vecs[6]  = '{1'b1, 6'd63, 4'd2, 1'b0, 8'h63, 1'b0, 8'h00};
        vecs[7]  = '{1'b0, 6'd63, 4'd2, 1'b0, 8'h00, 1'b0, 8'h63};
        vecs[8]  = '{1'b1, 6'd61, 4'd5, 1'b1, 8'h50, 1'b0, 8'h00};
        vecs[9]  = '{1'b0, 6'd56, 4'd2, 1'b0, 8'h00, 1'b0, 8'h53};
        vecs[10] = '{1'b1, 6'd12, 4'd0, 1'b0, 8'h00, 1'b1, 8'h00};
        vecs[11] = '{1'b0, 6'd12, 4'd0, 1'b0, 8'h00, 1'b1, 8'h00};
        vecs[12] = '{1'b0, 6'd61, 4'd5, 1'b1, 8'h00, 1'b0, 8'h50};

        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        // Read-done seen while idle must not start anything.
        rd_done = 1'b1;
        repeat (2) @(negedge clk);
        chk("rd_done_idle_busy", 32'(busy), 0);
        chk("rd_done_idle_valid", 32'(rd_valid), 0);
        rd_done = 1'b0;

        do_write(6'd0, 4'd3, 1'b0, 8'd3, -1, g);
        chk("lin_write_granted", 32'(g), 1);
        do_read(6'd0, 4'd3, 1'b0, 1, g, f);
        chk("readback_first", 32'(f), 3);
        chk("readback_ref2", 32'(ref_mem[2]), 5);

        for (int i = 0; i < 13; i++) begin
            if (vecs[i].is_wr) begin
                do_write(vecs[i].addr, vecs[i].num, vecs[i].wrap, vecs[i].d0,
                         (i % 2 == 1) ? 1 : -1, g);
            end else begin
                do_read(vecs[i].addr, vecs[i].num, vecs[i].wrap, i % 3, g, f);
                if (g) chk($sformatf("vec%0d_first", i), 32'(f), 32'(vecs[i].exp_first));
            end
            chk($sformatf("vec%0d_err", i), 32'(!g), 32'(vecs[i].exp_err));
        end

        // Abort a 4-beat write after two beats; the third beat must not land.
        do_req(1'b1, 6'd16, 4'd4, 1'b0, g);
        wr_valid = 1'b1; wr_data = 8'hE0;
        @(negedge clk);
        chk("abort_beat0", 32'(wr_done), 1);
        wr_data = 8'hE1;
        @(negedge clk);
        chk("abort_beat1", 32'(wr_done), 1);
        ref_mem[16] = 8'hE0;
        ref_mem[17] = 8'hE1;
        rst = 1'b1; wr_data = 8'hE2;
        @(negedge clk);
        chk_all_zero("abort");
        rst = 1'b0; wr_valid = 1'b0;
        @(negedge clk);
        chk("abort_idle", 32'(busy), 0);

        // Simultaneous requests after reset: write first, then read.
        wr_req = 1'b1; rd_req = 1'b1; addr = 6'd40; num_b = 4'd1; wrap = 1'b0;
        @(negedge clk);
        wr_req = 1'b0; rd_req = 1'b0;
        chk("arb1_ack", 32'(ack), 1);
        @(negedge clk);
        wr_valid = 1'b1; wr_data = 8'h77;
        @(negedge clk);
        chk("arb1_is_write", 32'(wr_done), 1);
        chk("arb1_no_rd", 32'(rd_valid), 0);
        chk("arb1_idle", 32'(busy), 0);
        ref_mem[40] = 8'h77;
        wr_valid = 1'b0;
        wr_req = 1'b1; rd_req = 1'b1; addr = 6'd8; num_b = 4'd1;
        @(negedge clk);
        wr_req = 1'b0; rd_req = 1'b0;
        chk("arb2_ack", 32'(ack), 1);
        @(negedge clk);
        wr_valid = 1'b1; wr_data = 8'h99;
        @(negedge clk);
        chk("arb2_is_read", 32'(rd_valid), 1);
        chk("arb2_no_wr", 32'(wr_done), 0);
        chk("arb2_data", 32'(rd_data), 32'h88);
        wr_valid = 1'b0; rd_done = 1'b1;
        @(negedge clk);
        rd_done = 1'b0;
        chk("arb2_idle", 32'(busy), 0);

        do_read(6'd40, 4'd1, 1'b0, 0, g, f);
        chk("arb_mem40", 32'(f), 32'h77);
        do_read(6'd16, 4'd4, 1'b0, 0, g, f);
        chk("abort_mem16", 32'(f), 32'hE0);
        chk("abort_ref18", 32'(ref_mem[18]), 32'h12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
